icache_dm: RTL and testbench

- Direct-mapped, read-only instruction cache directly downstream of the pipelined datapath's fetch stage.
- Consumes the fetch request (imemREN, imemaddr) and returns ihit and imemload to the PC and IF/ID register.
- On a miss it requests the word from the memory controller's instruction port, fills the frame, then reports a hit.
- One word per block; no writes and no coherence.

---
 rtl/icache_pkg.sv | 32 +++
 rtl/icache_frame_array.sv | 54 +++++
 rtl/icache_dm.sv | 134 +++++++++++++
 tb/tb_icache_dm.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// ============================================================================
// Module      : icache_pkg
// Description : Shared types for the direct-mapped instruction cache.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package icache_pkg;

    localparam int IC_IDX_W = 4;
    localparam int IC_TAG_W = 30 - IC_IDX_W;

    typedef struct packed {
        logic [IC_TAG_W-1:0] tag;
        logic [IC_IDX_W-1:0] idx;
        logic [1:0]          bytoff;
    } icachef_t;

    typedef struct packed {
        logic                valid;
        logic [IC_TAG_W-1:0] tag;
        logic [31:0]         data;
    } icache_frame_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } icache_state_t;

endpackage

`default_nettype wire

// File: rtl/icache_frame_array.sv
// ============================================================================
// Module      : icache_frame_array
// Description : Flop-based frame storage, one combinational read port and one
//               write port; valid bits clear on reset.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module icache_frame_array
    import icache_pkg::*;
#(
    parameter int SETS  = 16,
    parameter int IDX_W = $clog2(SETS),
    parameter int TAG_W = 30 - IDX_W
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic             rd_valid_o,
    output logic [TAG_W-1:0] rd_tag_o,
    output logic [31:0]      rd_data_o,
    input  logic             wen_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [TAG_W-1:0] wr_tag_i,
    input  logic [31:0]      wr_data_i
);

    logic [SETS-1:0]  valid_q;
    logic [TAG_W-1:0] tag_q  [SETS];
    logic [31:0]      data_q [SETS];

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            valid_q <= '0;
        end else if (wen_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    // Tag/data have no reset; a write coinciding with reset is dropped anyway.
    always_ff @(posedge CLK) begin
        if (nRST && wen_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i];

endmodule

`default_nettype wire

// File: rtl/icache_dm.sv
// ============================================================================
// Module      : icache_dm
// Description : Direct-mapped read-only instruction cache, one word per frame.
//               Define ICACHE_STATS_EN to add saturating hit/miss counters.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module icache_dm
    import icache_pkg::*;
#(
    parameter int SETS = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - IDX_W;

    localparam logic [0:0] S_IDLE  = IDLE;
    localparam logic [0:0] S_FETCH = FETCH;

    logic [0:0]       state_q, state_d;
    logic [29:0]      maddr_q, maddr_d;

    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic             w_rd_valid;
    logic [TAG_W-1:0] w_rd_tag;
    logic [31:0]      w_rd_data;
    logic             w_hit;
    logic             w_miss;
    logic             w_fill;
    logic             w_bytoff_unused;

    assign w_idx           = imemaddr[IDX_W+1:2];
    assign w_tag           = imemaddr[31:IDX_W+2];
    assign w_bytoff_unused = ^imemaddr[1:0];

    icache_frame_array #(
        .SETS  (SETS),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_frames (
        .CLK        (CLK),
        .nRST       (nRST),
        .rd_idx_i   (w_idx),
        .rd_valid_o (w_rd_valid),
        .rd_tag_o   (w_rd_tag),
        .rd_data_o  (w_rd_data),
        .wen_i      (w_fill),
        .wr_idx_i   (maddr_q[IDX_W-1:0]),
        .wr_tag_i   (maddr_q[29:IDX_W]),
        .wr_data_i  (iload)
    );

    assign w_hit  = (state_q == S_IDLE) && imemREN && w_rd_valid && (w_rd_tag == w_tag);
    assign w_miss = (state_q == S_IDLE) && imemREN && !w_hit;
    assign w_fill = (state_q == S_FETCH) && !iwait;

    always_comb begin
        state_d = state_q;
        maddr_d = maddr_q;
        case (state_q)
            S_IDLE: begin
                if (w_miss) begin
                    state_d = S_FETCH;
                    maddr_d = imemaddr[31:2];
                end
            end
            S_FETCH: begin
                // The fetch ignores imemaddr from here on; a redirect is seen after the fill.
                if (!iwait) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= S_IDLE;
            maddr_q <= '0;
        end else begin
            state_q <= state_d;
            maddr_q <= maddr_d;
        end
    end

    assign ihit     = w_hit;
    assign imemload = w_hit ? w_rd_data : 32'h0;
    assign iREN     = (state_q == S_FETCH);
    assign iaddr    = {maddr_q, 2'b00};

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (w_hit && (hit_cnt_q != 32'hFFFF_FFFF)) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (w_miss && (miss_cnt_q != 32'hFFFF_FFFF)) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_icache_dm.sv
// ============================================================================
// Module      : tb_icache_dm
// Description : Scoreboard bench for icache_dm against a transaction-level
//               cache model; honours ICACHE_STATS_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_icache_dm;

    typedef struct {
        logic [31:0] data;
        int          start;
        int          lat;
    } exp_t;

    typedef struct {
        logic [29:0] w;
        int          n;
    } fetch_t;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        imemREN = 1'b0;
    logic [31:0] imemaddr = 32'h0;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait = 1'b1;
    logic [31:0] iload = 32'h0;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int hits_seen = 0;
    int m_hit = 0;
    int m_miss = 0;

    exp_t   exp_q[$];
    fetch_t fetch_q[$];
    int     wait_q[$];

    logic [31:0] mem    [logic [29:0]];
    logic [29:0] m_line [int];
    logic [31:0] m_data [int];

    icache_dm dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .imemREN    (imemREN),
        .imemaddr   (imemaddr),
        .ihit       (ihit),
        .imemload   (imemload),
        .iREN       (iREN),
        .iaddr      (iaddr),
        .iwait      (iwait),
        .iload      (iload)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] memword(input logic [29:0] w);
        if (mem.exists(w)) return mem[w];
        return ({2'b00, w} * 32'h9E37_79B1) ^ 32'h1234_ABCD;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Memory controller: each fetch takes its wait count from wait_q.
    initial begin : responder
        int  cnt;
        int  lim;
        bit  active;
        cnt = 0; lim = 0; active = 0;
        forever begin
            @(posedge CLK); #1;
            if (iREN) begin
                if (!active) begin
                    active = 1;
                    cnt    = 0;
                    lim    = (wait_q.size() > 0) ? wait_q.pop_front() : 0;
                end
                if (cnt < lim) begin
                    iwait = 1'b1;
                    iload = $urandom;
                    cnt++;
                end else begin
                    iwait = 1'b0;
                    iload = memword(iaddr[31:2]);
                end
            end else begin
                active = 0;
                iwait  = 1'($urandom_range(0, 1));
                iload  = $urandom;
            end
        end
    end

    initial begin : monitor
        exp_t   e;
        fetch_t cur;
        bit     in_fetch;
        int     run;
        in_fetch = 0; run = 0; cur.w = '0; cur.n = 0;
        forever begin
            @(negedge CLK);
            cyc++;
            if (!nRST) begin
                in_fetch = 0;
            end else begin
                if (ihit) begin
                    if (exp_q.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL unexpected_ihit: got ihit=1 with addr %h, required none", imemaddr);
                    end else begin
                        e = exp_q.pop_front();
                        chk("imemload", imemload, e.data);
                        chk("hit_latency", 32'(cyc - e.start), 32'(e.lat));
                    end
                    hits_seen++;
                end else begin
                    chk("imemload_no_hit", imemload, 32'h0);
                end
                if (iREN) begin
                    if (!in_fetch) begin
                        in_fetch = 1;
                        run      = 0;
                        if (fetch_q.size() == 0) begin
                            n_chk++; n_fail++;
                            $display("FAIL unexpected_iREN: got iREN=1 iaddr %h, required no fetch", iaddr);
                            cur.w = iaddr[31:2]; cur.n = 0;
                        end else begin
                            cur = fetch_q.pop_front();
                        end
                    end
                    run++;
                    chk("iaddr", iaddr, {cur.w, 2'b00});
                end else if (in_fetch) begin
                    in_fetch = 0;
                    chk("iREN_cycles", 32'(run), 32'(cur.n + 1));
                end
            end
        end
    end

    task automatic model_reset();
        m_line.delete();
        m_data.delete();
        m_hit = 0;
        m_miss = 0;
        exp_q.delete();
        fetch_q.delete();
        wait_q.delete();
    endtask

    task automatic wait_hits(input int target);
        int k;
        k = 0;
        while (hits_seen < target && k < 200) begin
            @(posedge CLK);
            k++;
        end
        #1;
        imemREN = 1'b0;
        if (hits_seen < target) begin
            n_chk++; n_fail++;
            $display("FAIL hit_timeout: saw %0d hits, required %0d", hits_seen, target);
            exp_q.delete(); fetch_q.delete(); wait_q.delete();
            hits_seen = target;
        end
    endtask

    // Returns 1 if the model says the word is resident; on a miss, queues the fill.
    function automatic bit model_access(input logic [31:0] a, input int nw);
        int          idx;
        logic [29:0] w;
        idx = int'(a[5:2]);
        w   = a[31:2];
        if (m_line.exists(idx) && m_line[idx] == w) return 1;
        wait_q.push_back(nw);
        fetch_q.push_back('{w: w, n: nw});
        m_line[idx] = w;
        m_data[idx] = memword(w);
        m_miss++;
        return 0;
    endfunction

    task automatic fetch(input logic [31:0] a, input int nw);
        exp_t e;
        bit   hit;
        int   target;
        @(posedge CLK); #1;
        imemREN  = 1'b1;
        imemaddr = a;
        target   = hits_seen + 1;
        hit      = model_access(a, nw);
        e.data   = m_data[int'(a[5:2])];
        e.start  = cyc + 1;
        e.lat    = hit ? 0 : nw + 2;
        m_hit++;
        exp_q.push_back(e);
        wait_hits(target);
    endtask

    // Miss on a, then switch to b one cycle later; the fill of a must complete.
    task automatic redirect(input logic [31:0] a, input int nw, input logic [31:0] b, input int nw2);
        exp_t e;
        bit   hit_b;
        int   target;
        @(posedge CLK); #1;
        imemREN  = 1'b1;
        imemaddr = a;
        target   = hits_seen + 1;
        e.start  = cyc + 1;
        void'(model_access(a, nw));
        @(posedge CLK); #1;
        imemaddr = b;
        hit_b    = model_access(b, nw2);
        e.data   = m_data[int'(b[5:2])];
        e.lat    = hit_b ? nw + 2 : nw + 2 + nw2 + 2;
        m_hit++;
        exp_q.push_back(e);
        wait_hits(target);
    endtask

    task automatic do_reset(input bit check_ren);
        @(posedge CLK); #1;
        nRST    = 1'b0;
        imemREN = 1'b0;
        model_reset();
        @(posedge CLK);
        @(negedge CLK);
        if (check_ren) chk("iREN_after_reset", {31'h0, iREN}, 32'h0);
        @(posedge CLK); #1;
        nRST = 1'b1;
    endtask

    task automatic reset_in_fetch(input logic [31:0] a, input int nw, input int k);
        @(posedge CLK); #1;
        imemREN  = 1'b1;
        imemaddr = a;
        void'(model_access(a, nw));
        repeat (k) @(posedge CLK);
        #1;
        nRST    = 1'b0;
        imemREN = 1'b0;
        model_reset();
        @(posedge CLK);
        @(negedge CLK);
        chk("iREN_after_reset", {31'h0, iREN}, 32'h0);
        @(posedge CLK); #1;
        nRST = 1'b1;
        fetch(a, 1);
    endtask

    task automatic check_stats();
`ifdef ICACHE_STATS_EN
        @(negedge CLK);
        chk("hit_count", hit_count, 32'(m_hit));
        chk("miss_count", miss_count, 32'(m_miss));
`endif
    endtask

    function automatic logic [31:0] rand_addr();
        return {4'($urandom_range(0, 1) << 3), 20'h0, 2'($urandom_range(0, 3)),
                4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
    endfunction

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [31:0] a;
        logic [31:0] b;
        mem[30'd0]  = 32'hAAAA_0000;
        mem[30'd1]  = 32'h8C01_0004;
        mem[30'd16] = 32'hBBBB_0040;

        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b1;
        imemaddr = 32'h0;
        @(negedge CLK);
        chk("reset_ihit", {31'h0, ihit}, 32'h0);
        chk("reset_iREN", {31'h0, iREN}, 32'h0);
        chk("reset_iaddr", iaddr, 32'h0);
        check_stats();

        fetch(32'h0000_0000, 0);
        fetch(32'h0000_0004, 3);
        fetch(32'h0000_0006, 0);
        fetch(32'h0000_0040, 1);
        fetch(32'h0000_0000, 2);
        fetch(32'h0000_0040, 0);

        @(posedge CLK); #1;
        imemREN  = 1'b0;
        imemaddr = 32'h0000_0004;
        repeat (5) begin
            @(negedge CLK);
            chk("idle_ihit", {31'h0, ihit}, 32'h0);
            chk("idle_iREN", {31'h0, iREN}, 32'h0);
        end
        fetch(32'h0000_0004, 0);
        check_stats();

        reset_in_fetch(32'h0000_0008, 10, 3);
        reset_in_fetch(32'h0000_000C, 2, 3);

        do_reset(1'b0);
        fetch(32'h0000_0004, 2);
        fetch(32'h0000_0004, 0);
        fetch(32'h0000_0004, 0);
        check_stats();

        for (int t = 0; t < 300; t++) begin
            a = rand_addr();
            if ($urandom_range(0, 7) == 0 &&
                !(m_line.exists(int'(a[5:2])) && m_line[int'(a[5:2])] == a[31:2])) begin
                do b = rand_addr(); while (b[31:2] == a[31:2]);
                redirect(a, $urandom_range(0, 4), b, $urandom_range(0, 3));
            end else begin
                fetch(a, $urandom_range(0, 4));
            end
            repeat ($urandom_range(0, 2)) begin
                @(posedge CLK); #1;
                imemaddr = rand_addr();
            end
        end
        check_stats();

        repeat (3) @(posedge CLK);
        chk("leftover_expectations", 32'(exp_q.size()), 32'h0);
        chk("leftover_fetches", 32'(fetch_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
